// File: rtl/on_the_fly_noc2node_pkg.sv
// Shared widths, defaults and field types for the NoC-to-node pending table.
// Header-flit widths fall back to local values when the NoC defines are absent.
`ifndef N_BIT_SRC_HEAD_FLIT
`define N_BIT_SRC_HEAD_FLIT 6
`endif
`ifndef N_BIT_DEST_HEAD_FLIT
`define N_BIT_DEST_HEAD_FLIT 6
`endif
`ifndef N_BIT_CMD_HEAD_FLIT
`define N_BIT_CMD_HEAD_FLIT 3
`endif
`ifndef TABLE_PENDING_NOC2NODE_WIDTH
`define TABLE_PENDING_NOC2NODE_WIDTH 8
`endif
`ifndef NOC2NODE_TIMEOUT_CYCLES
`define NOC2NODE_TIMEOUT_CYCLES 1024
`endif

package on_the_fly_noc2node_pkg;

  localparam int SRC_W = `N_BIT_SRC_HEAD_FLIT;
  localparam int DST_W = `N_BIT_DEST_HEAD_FLIT;
  localparam int CMD_W = `N_BIT_CMD_HEAD_FLIT;

  localparam int DEF_PTR_W   = $clog2(`TABLE_PENDING_NOC2NODE_WIDTH);
  localparam int DEF_TIMEOUT = `NOC2NODE_TIMEOUT_CYCLES;

  typedef logic [SRC_W-1:0] src_t;
  typedef logic [DST_W-1:0] dst_t;
  typedef logic [CMD_W-1:0] cmd_t;

endpackage

// File: rtl/on_the_fly_noc2node_watchdog.sv
// Head-of-table watchdog: counts while the head waits, pulses fire_o on expiry.
// A zero TIMEOUT_CYCLES ties the counter off and never fires.
module on_the_fly_noc2node_watchdog #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int N_BITS_TIMEOUT = 11
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic clr_i,
  output logic fire_o
);

  localparam bit ON = (TIMEOUT_CYCLES != 0);
  localparam logic [N_BITS_TIMEOUT-1:0] LAST =
    N_BITS_TIMEOUT'(TIMEOUT_CYCLES - 1);

  logic [N_BITS_TIMEOUT-1:0] cnt_q, cnt_d;

  assign fire_o = ON && en_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr_i || !en_i || !ON || fire_o)
      cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/on_the_fly_noc2node.sv
// Pending-request table for NoC-originated transactions: tags issued in order,
// completed in any order, replies released in order with a head watchdog.
module on_the_fly_noc2node
  import on_the_fly_noc2node_pkg::*;
#(
  parameter int N_BITS_POINTER = DEF_PTR_W,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT,
  parameter int N_BITS_TIMEOUT = 11
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      alloc_i,
  input  src_t                      alloc_sender_i,
  input  dst_t                      alloc_recipient_i,
  input  cmd_t                      alloc_cmd_i,
  output logic [N_BITS_POINTER-1:0] alloc_tag_o,
  output logic                      full_o,
  output logic                      empty_o,
  output logic [N_BITS_POINTER:0]   count_o,
  input  logic                      done_i,
  input  logic [N_BITS_POINTER-1:0] done_tag_i,
  input  logic                      done_error_i,
  output logic                      head_valid_o,
  output logic [N_BITS_POINTER-1:0] head_tag_o,
  output src_t                      head_sender_o,
  output dst_t                      head_recipient_o,
  output cmd_t                      head_cmd_o,
  output logic                      head_error_o,
  output logic                      head_timeout_o,
  input  logic                      head_ack_i
);

  localparam int N = 1 << N_BITS_POINTER;
  localparam logic [N_BITS_POINTER:0] CNT_FULL = (N_BITS_POINTER+1)'(N);

  typedef logic [N_BITS_POINTER-1:0] ptr_t;

  logic [N-1:0] valid_q, valid_d;
  logic [N-1:0] done_q, done_d;
  logic [N-1:0] err_q, err_d;
  logic [N-1:0] to_q, to_d;
  ptr_t         head_q, head_d;
  ptr_t         tail_q, tail_d;
  logic [N_BITS_POINTER:0] count_q, count_d;

  src_t sender_q    [N];
  dst_t recipient_q [N];
  cmd_t cmd_q       [N];

  logic alloc_ok, retire, done_ok, head_wait, wd_fire;

  assign full_o  = (count_q == CNT_FULL);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

  assign alloc_tag_o = tail_q;
  assign head_tag_o  = head_q;

  assign head_valid_o   = valid_q[head_q] & (done_q[head_q] | to_q[head_q]);
  assign head_error_o   = err_q[head_q];
  assign head_timeout_o = to_q[head_q];

  assign head_sender_o    = sender_q[head_q];
  assign head_recipient_o = recipient_q[head_q];
  assign head_cmd_o       = cmd_q[head_q];

  assign alloc_ok = alloc_i & ~full_o;
  assign retire   = head_ack_i & head_valid_o;
  assign done_ok  = done_i & valid_q[done_tag_i]
                  & ~done_q[done_tag_i] & ~to_q[done_tag_i];

  assign head_wait = valid_q[head_q] & ~done_q[head_q] & ~to_q[head_q];

  on_the_fly_noc2node_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .N_BITS_TIMEOUT (N_BITS_TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .en_i   (head_wait),
    .clr_i  (retire),
    .fire_o (wd_fire)
  );

  always_comb begin
    valid_d = valid_q;
    done_d  = done_q;
    err_d   = err_q;
    to_d    = to_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (done_ok) begin
      done_d[done_tag_i] = 1'b1;
      err_d[done_tag_i]  = done_error_i;
    end
    // a completion landing on the head in the expiry cycle beats the timeout
    if (wd_fire && !(done_ok && done_tag_i == head_q))
      to_d[head_q] = 1'b1;
    if (retire) begin
      valid_d[head_q] = 1'b0;
      done_d[head_q]  = 1'b0;
      err_d[head_q]   = 1'b0;
      to_d[head_q]    = 1'b0;
      head_d          = head_q + 1'b1;
    end
    if (alloc_ok) begin
      valid_d[tail_q] = 1'b1;
      tail_d          = tail_q + 1'b1;
    end
    case ({alloc_ok, retire})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      done_q  <= '0;
      err_q   <= '0;
      to_q    <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      done_q  <= done_d;
      err_q   <= err_d;
      to_q    <= to_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (alloc_ok) begin
      sender_q[tail_q]    <= alloc_sender_i;
      recipient_q[tail_q] <= alloc_recipient_i;
      cmd_q[tail_q]       <= alloc_cmd_i;
    end
  end

endmodule

// File: doc/on_the_fly_noc2node.md
Name: on_the_fly_noc2node

Overview:
- Table of pending transactions arriving from the NoC: requests from remote masters now being served by slaves on the local WISHBONE bus.
- Each request gets a tag on entry. The local slave side completes tags in any order.
- Replies are released to the NoC injector strictly in arrival order, reorder-buffer style.
- A per-head watchdog retires stalled requests with a timeout flag so the remote master is never left waiting forever.

Parameters:
- N_BITS_POINTER, 3: tag/pointer width. Table depth N_ENTRIES = 2**N_BITS_POINTER (8).
- TIMEOUT_CYCLES, 1024: cycles the head entry may wait for completion before forced timeout. 0 disables the watchdog.
- N_BITS_TIMEOUT, 11: width of the watchdog counter. Must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- alloc_i  in  1  store a new incoming request this cycle
- alloc_sender_i  in  `N_BIT_SRC_HEAD_FLIT  remote source node
- alloc_recipient_i  in  `N_BIT_DEST_HEAD_FLIT  local destination
- alloc_cmd_i  in  `N_BIT_CMD_HEAD_FLIT  transaction type
- alloc_tag_o  out  N_BITS_POINTER  tag the next alloc receives (tail pointer)
- full_o  out  1  all entries occupied
- empty_o  out  1  no entries occupied
- count_o  out  N_BITS_POINTER+1  occupied entries
- done_i  in  1  local slave finished a request
- done_tag_i  in  N_BITS_POINTER  tag being completed
- done_error_i  in  1  slave signalled an error (ERR_I)
- head_valid_o  out  1  oldest entry ready for reply
- head_tag_o  out  N_BITS_POINTER  head pointer
- head_sender_o / head_recipient_o / head_cmd_o  out  field widths  head entry contents
- head_error_o  out  1  head completed with error
- head_timeout_o  out  1  head retired by watchdog
- head_ack_i  in  1  reply injector consumed the head

Behaviour:
- Reset (rst high at a clk edge):
  - All valid/done/error/timeout bits cleared; head = tail = 0; watchdog = 0.
  - count_o = 0, empty_o = 1, full_o = 0, head_valid_o = 0, head_error_o = 0, head_timeout_o = 0.
  - Field storage is not reset.
  - Reset mid-operation drops all entries with no reply generated.
- Alloc:
  - If alloc_i and !full_o: fields are written at tail and valid is set; tail increments mod N_ENTRIES.
  - alloc_tag_o is combinational from tail, so the issuer latches it in the same cycle.
  - alloc_i while full_o is ignored, even if head_ack_i retires an entry that cycle. No state change.
- Done:
  - If done_i and entry[done_tag_i] is valid, not done and not timed out: set done, and set error = done_error_i. Visible on head_* the next cycle.
  - done_i on an invalid, already-done or timed-out tag is ignored. A late completion after a timeout never changes a retired flag.
- Head:
  - head_valid_o = valid[head] & (done[head] | timeout[head]). Combinational from registers.
  - head_* fields are driven from entry[head] whenever that entry is valid; otherwise don't-care.
- Retire:
  - If head_ack_i and head_valid_o: clear valid/done/error/timeout of head; head increments mod N_ENTRIES.
  - head_ack_i without head_valid_o is ignored.
- Watchdog:
  - Counter increments each cycle while valid[head] & !done[head] & !timeout[head] and TIMEOUT_CYCLES != 0.
  - When the counter reaches TIMEOUT_CYCLES-1 and increments: set timeout[head]; head_valid_o rises the next cycle with head_timeout_o = 1.
  - The counter clears on retire, and whenever the head entry is done, timed out or invalid.
  - done_i on the head in the same cycle the timeout fires: done wins, timeout is not set.
- Count:
  - count_o +1 on accepted alloc, -1 on accepted retire, unchanged if both occur.
  - full_o = (count_o == N_ENTRIES); empty_o = (count_o == 0).
- Pointers wrap naturally in N_BITS_POINTER bits.
- Completion order is free; reply order equals alloc order.

Decomposition:
- Shared defines already in the defines include: `N_BIT_SRC_HEAD_FLIT, `N_BIT_DEST_HEAD_FLIT, `N_BIT_CMD_HEAD_FLIT.
- Add `TABLE_PENDING_NOC2NODE_WIDTH (8) and `NOC2NODE_TIMEOUT_CYCLES (1024) to the same defines file. Parameter defaults take their values from these.
- One sub-module is natural: on_the_fly_noc2node_watchdog (counter, enable, clear, fire pulse).
- The table stays flat in the top module.

Test Plan:
- Reset then alloc 3 requests (senders 1,2,3) -> alloc_tag_o 0,1,2; count_o = 3; head_valid_o = 0.
- done tags 2, then 0, then 1 -> head_valid_o rises one cycle after done tag 0; head_sender_o = 1.
  - Ack three times -> senders presented in order 1,2,3; empty_o = 1.
- Fill 8 entries -> full_o = 1.
  - 9th alloc -> ignored, count_o stays 8.
  - Same-cycle alloc + ack while full -> alloc still ignored, count_o = 7.
- TIMEOUT_CYCLES = 16, alloc 1, no done -> head_valid_o = 1 and head_timeout_o = 1 exactly 17 cycles after alloc.
  - Later done_i on that tag -> no change.
- done_i with done_error_i = 1 on head -> head_error_o = 1.
  - done_i on an unallocated tag -> no state change.
  - Wrap test: 20 alloc/complete/ack rounds -> tags cycle 0..7,0..; count_o never exceeds 8.
- Assert rst with 5 pending, 2 done -> next cycle count_o = 0, head_valid_o = 0, alloc_tag_o = 0.
